// File: rtl/duty_mux_sync_if.sv
`default_nettype none
// ============================================================================
// Module   : duty_mux_sync_if
// Brief    : Channel-select bus for the period-synchronised duty mux.
// Revision : 1.0 - initial release
// ============================================================================
interface duty_mux_sync_if #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  parameter int SEL_W = 2
);
  logic [NCH*WIDTH-1:0] din;
  logic [SEL_W-1:0]     sel;
  logic                 sel_load;
  logic                 period_tick;
  logic [WIDTH-1:0]     y;
  logic [SEL_W-1:0]     sel_active;
  logic                 pending;
  logic                 switch_done;
  logic                 sel_err;

  modport master (
    output din, sel, sel_load, period_tick,
    input  y, sel_active, pending, switch_done, sel_err
  );

  modport slave (
    input  din, sel, sel_load, period_tick,
    output y, sel_active, pending, switch_done, sel_err
  );
endinterface
`default_nettype wire

// File: rtl/duty_mux_sync.sv
`default_nettype none
// ============================================================================
// Module   : duty_mux_sync
// Brief    : Registered N-channel mux whose select switches only on a DPWM
//            period boundary when DUTY_MUX_SYNC_EN is defined; otherwise a
//            valid load switches the select immediately.
// Revision : 1.0 - initial release
// ============================================================================
module duty_mux_sync #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  parameter int SEL_W = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  duty_mux_sync_if.slave       bus
);

  localparam int               NSLOT = 1 << SEL_W;
  localparam logic [SEL_W:0]   NCH_L = (SEL_W + 1)'(NCH);

  // Unpopulated select codes read as zero so the index always fits the array.
  logic [WIDTH-1:0] chan [NSLOT];

  generate
    for (genvar k = 0; k < NSLOT; k++) begin : g_chan
      if (k < NCH) begin : g_used
        assign chan[k] = bus.din[k*WIDTH +: WIDTH];
      end else begin : g_unused
        assign chan[k] = '0;
      end
    end
  endgenerate

  logic sel_ok;
  logic load_ok;
  logic load_bad;

  assign sel_ok   = ({1'b0, bus.sel} < NCH_L);
  assign load_ok  = bus.sel_load & sel_ok;
  assign load_bad = bus.sel_load & ~sel_ok;

  logic [WIDTH-1:0] y_q,           y_d;
  logic [SEL_W-1:0] active_q,      active_d;
  logic             switch_done_q, switch_done_d;
  logic             sel_err_q,     sel_err_d;

  always_comb begin
    y_d       = chan[active_q];
    sel_err_d = load_bad;
  end

`ifdef DUTY_MUX_SYNC_EN
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t           state_q,  state_d;
  logic [SEL_W-1:0] shadow_q, shadow_d;

  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    switch_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_ok) begin
          shadow_d = bus.sel;
          state_d  = PEND;
        end
      end
      PEND: begin
        if (bus.period_tick) begin
          active_d      = shadow_q;
          switch_done_d = 1'b1;
          state_d       = IDLE;
        end
        // A load coinciding with the commit becomes the next pending select.
        if (load_ok) begin
          shadow_d = bus.sel;
          state_d  = PEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
    end
  end

  assign bus.pending = (state_q == PEND);
`else
  logic unused_tick;
  assign unused_tick = bus.period_tick;

  always_comb begin
    active_d      = active_q;
    switch_done_d = 1'b0;
    if (load_ok) begin
      active_d      = bus.sel;
      switch_done_d = 1'b1;
    end
  end

  assign bus.pending = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q           <= '0;
      active_q      <= '0;
      switch_done_q <= 1'b0;
      sel_err_q     <= 1'b0;
    end else begin
      y_q           <= y_d;
      active_q      <= active_d;
      switch_done_q <= switch_done_d;
      sel_err_q     <= sel_err_d;
    end
  end

  assign bus.y           = y_q;
  assign bus.sel_active  = active_q;
  assign bus.switch_done = switch_done_q;
  assign bus.sel_err     = sel_err_q;

endmodule
`default_nettype wire

// File: doc/duty_mux_sync.md
DUTY_MUX_SYNC -- requirements
Module: duty_mux_sync

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, bit width of each data channel.
REQ-002 SHALL provide parameter NCH, default 4, number of input channels (legal range 2..16).
REQ-003 SHALL provide parameter SEL_W, default 2, select width; 2**SEL_W >= NCH is required.
REQ-004 SHALL have port clk, input, 1 bit, single clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port din, input, NCH*WIDTH bits, packed channels; channel k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
REQ-007 SHALL have port sel, input, SEL_W bits, requested channel index.
REQ-008 SHALL have port sel_load, input, 1 bit, one-cycle strobe capturing sel.
REQ-009 SHALL have port period_tick, input, 1 bit, one-cycle strobe marking the DPWM period boundary.
REQ-010 SHALL have port y, output, WIDTH bits, registered selected channel data.
REQ-011 SHALL have port sel_active, output, SEL_W bits, channel currently driving y.
REQ-012 SHALL have port pending, output, 1 bit, a captured select awaits commit.
REQ-013 SHALL have port switch_done, output, 1 bit, one-cycle pulse on the cycle a commit takes effect.
REQ-014 SHALL have port sel_err, output, 1 bit, one-cycle pulse on a rejected out-of-range load.

Function
REQ-015 SHALL hold a shadow select register, an active select register and a two-state FSM: IDLE (pending=0), PEND (pending=1).
REQ-016 SHALL, on sel_load with sel < NCH, write sel into shadow and enter PEND at the next edge.
REQ-017 SHALL, on sel_load with sel >= NCH, leave shadow, FSM and active unchanged and pulse sel_err for exactly one cycle.
REQ-018 SHALL, in PEND with period_tick=1, copy shadow into active, return to IDLE and pulse switch_done in the same edge.
REQ-019 SHALL ignore period_tick in IDLE: no state change, no switch_done.
REQ-020 SHALL, in PEND, let a further valid sel_load overwrite shadow (last write wins), remaining in PEND.
REQ-021 SHALL, on simultaneous valid sel_load and period_tick in PEND, commit the old shadow to active and capture the new sel into shadow, remaining in PEND.
REQ-022 SHALL, on simultaneous valid sel_load and period_tick in IDLE, capture sel into shadow and enter PEND without committing; commit occurs on a later tick.
REQ-023 SHALL update y every cycle as y <= channel[active], one-cycle latency from din to y; y never reflects a partially updated select.
REQ-024 SHALL, on the commit edge, load y from the newly committed channel one cycle later (y uses the registered active value).
REQ-025 SHALL drive sel_active directly from the active register.

Reset
REQ-026 SHALL, while reset=1, asynchronously force y=0, active=0, shadow=0, FSM=IDLE, pending=0, switch_done=0, sel_err=0.
REQ-027 SHALL, on reset asserted mid-PEND, discard the pending select; after release, active=0 until a new load/commit.
REQ-028 SHALL ignore sel_load and period_tick in the cycle reset is asserted.

Configuration
REQ-029 SHALL support macro DUTY_MUX_SYNC_EN.
REQ-030 SHALL, with DUTY_MUX_SYNC_EN defined, implement period-aligned commit per REQ-015..REQ-022.
REQ-031 SHALL, without DUTY_MUX_SYNC_EN, commit a valid sel_load directly into active on the same edge with a switch_done pulse; shadow unused, pending constantly 0, period_tick ignored; range check and sel_err unchanged.

Verification
REQ-032 SHALL cover: reset, din=0xDCBA (NCH=4, WIDTH=4) -> after release y=0xA, sel_active=0, pending=0.
REQ-033 SHALL cover: sel=2 with sel_load, no tick for 10 cycles -> y stays 0xA, pending=1; tick -> switch_done pulse, sel_active=2, y=0xC the following cycle.
REQ-034 SHALL cover: NCH=3, sel=3 with sel_load -> sel_err one-cycle pulse, pending unchanged, sel_active unchanged.
REQ-035 SHALL cover: loads sel=1 then sel=3 before tick -> tick commits 3, y=0xD.
REQ-036 SHALL cover: PEND with shadow=1, sel=2 load and tick in same cycle -> sel_active=1, pending stays 1; next tick -> sel_active=2.
REQ-037 SHALL cover: reset asserted while pending=1 -> all outputs 0 immediately; subsequent tick with no load -> no switch_done, sel_active=0.
